axi4_write_slave: RTL

//  AXI4 write-channel responder (AW/W/B) backed by an internal word-addressed memory; the slave end driven by the write-path bench.

---
 rtl/axi4_write_slave.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/axi4_write_slave.sv
// axi4_write_slave: AXI4 write-channel responder (AW/W/B) backed by a word-addressed memory.
// Only one INCR burst is in flight at a time. An illegal burst still completes on its beat
// count, writes nothing, and answers SLVERR.
// Optional define AXI_WSTRB_EN: adds the WSTRB port and gates the narrow-lane mask with it.
// Lane arithmetic assumes DATA_WIDTH >= 16 and an address space of at least one 4KB page.
module axi4_write_slave #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 16,
   parameter int MEM_DEPTH  = 1024
) (
   input  logic                         clk,
   input  logic                         ARESET,
   input  logic [ADDR_WIDTH-1:0]        AWADDR,
   input  logic [7:0]                   AWLEN,
   input  logic [2:0]                   AWSIZE,
   input  logic                         AWVALID,
   output logic                         AWREADY,
   input  logic [DATA_WIDTH-1:0]        WDATA,
`ifdef AXI_WSTRB_EN
   input  logic [DATA_WIDTH/8-1:0]      WSTRB,
`endif
   input  logic                         WLAST,
   input  logic                         WVALID,
   output logic                         WREADY,
   output logic [1:0]                   BRESP,
   output logic                         BVALID,
   input  logic                         BREADY,
   input  logic [$clog2(MEM_DEPTH)-1:0] dbg_addr,
   output logic [DATA_WIDTH-1:0]        dbg_rdata
);

   localparam int          NB        = DATA_WIDTH / 8;
   localparam int          LB        = $clog2(NB);
   localparam int          IW        = $clog2(MEM_DEPTH);
   localparam logic [2:0]  MAX_SIZE  = 3'(LB);
   localparam logic [31:0] MEM_BYTES = 32'(MEM_DEPTH * NB);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_DATA = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   logic [1:0]            state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [7:0]            len_q, len_d;
   logic [2:0]            size_q, size_d;
   logic [7:0]            beat_q, beat_d;
   logic                  err_q, err_d;
   logic                  awready_q, awready_d;
   logic                  wready_q, wready_d;
   logic                  bvalid_q, bvalid_d;
   logic [1:0]            bresp_q, bresp_d;

   logic [31:0]           aw_span, aw_aligned, aw_last;
   logic                  aw_err;

   logic [ADDR_WIDTH-1:0] beat_bytes, beat_aligned;
   logic [7:0]            lane_lo, lane_hi;
   logic [NB-1:0]         lane_we;
   logic                  beat_fire, beat_is_last, wlast_err, wr_en;
   logic [IW-1:0]         wr_idx;

   logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

   // Burst legality at AW time: size fits the bus, burst stays in its 4KB page, last beat lands in memory
   always_comb begin
      aw_span    = 32'(AWADDR[11:0]) + ((32'(AWLEN) + 32'd1) << AWSIZE);
      aw_aligned = (32'(AWADDR) >> AWSIZE) << AWSIZE;
      aw_last    = aw_aligned + (32'(AWLEN) << AWSIZE);
      aw_err     = (AWSIZE > MAX_SIZE) || (aw_span > 32'd4096) || (aw_last >= MEM_BYTES);
   end

   // Per-beat lane mask and write enable; an unaligned first beat starts at addr % NB
   always_comb begin
      beat_fire    = (state_q == S_DATA) && WVALID && wready_q;
      beat_is_last = (beat_q == len_q);
      wlast_err    = beat_fire && (WLAST != beat_is_last);
      beat_bytes   = ADDR_WIDTH'(1) << size_q;
      beat_aligned = (addr_q >> size_q) << size_q;
      lane_lo      = 8'(addr_q[LB-1:0]);
      lane_hi      = 8'(beat_aligned[LB-1:0]) + 8'(beat_bytes) - 8'd1;
      for (int i = 0; i < NB; i++) begin
         lane_we[i] = (8'(i) >= lane_lo) && (8'(i) <= lane_hi);
      end
`ifdef AXI_WSTRB_EN
      lane_we = lane_we & WSTRB;
`endif
      // A WLAST violation suppresses the offending beat as well as the rest of the burst
      wr_en  = beat_fire && !err_q && !wlast_err;
      wr_idx = addr_q[LB +: IW];
   end

   // Next-state logic for the IDLE -> DATA -> RESP handshake sequence
   always_comb begin
      // NOTE: every signal gets a default first, so no path through the case can infer a latch.
      state_d   = state_q;
      addr_d    = addr_q;
      len_d     = len_q;
      size_d    = size_q;
      beat_d    = beat_q;
      err_d     = err_q;
      awready_d = awready_q;
      wready_d  = wready_q;
      bvalid_d  = bvalid_q;
      bresp_d   = bresp_q;
      case (state_q)
         S_IDLE: begin
            awready_d = 1'b1;
            if (AWVALID && awready_q) begin
               awready_d = 1'b0;
               wready_d  = 1'b1;
               addr_d    = AWADDR;
               len_d     = AWLEN;
               size_d    = AWSIZE;
               beat_d    = 8'd0;
               err_d     = aw_err;
               state_d   = S_DATA;
            end
         end
         S_DATA: begin
            if (beat_fire) begin
               addr_d = beat_aligned + beat_bytes;
               beat_d = beat_q + 8'd1;
               if (wlast_err) begin
                  err_d = 1'b1;
               end
               // Completion is by beat count, regardless of where WLAST appeared
               if (beat_is_last) begin
                  wready_d = 1'b0;
                  bvalid_d = 1'b1;
                  bresp_d  = (err_q || wlast_err) ? RESP_SLVERR : RESP_OKAY;
                  state_d  = S_RESP;
               end
            end
         end
         S_RESP: begin
            if (bvalid_q && BREADY) begin
               bvalid_d  = 1'b0;
               bresp_d   = RESP_OKAY;
               awready_d = 1'b1;
               state_d   = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Control and handshake registers, asynchronously reset
   always_ff @(posedge clk or posedge ARESET) begin
      if (ARESET) begin
         state_q   <= S_IDLE;
         addr_q    <= '0;
         len_q     <= '0;
         size_q    <= '0;
         beat_q    <= '0;
         err_q     <= 1'b0;
         awready_q <= 1'b0;
         wready_q  <= 1'b0;
         bvalid_q  <= 1'b0;
         bresp_q   <= RESP_OKAY;
      end else begin
         // NOTE: non-blocking assignments so every flop samples the pre-edge values.
         state_q   <= state_d;
         addr_q    <= addr_d;
         len_q     <= len_d;
         size_q    <= size_d;
         beat_q    <= beat_d;
         err_q     <= err_d;
         awready_q <= awready_d;
         wready_q  <= wready_d;
         bvalid_q  <= bvalid_d;
         bresp_q   <= bresp_d;
      end
   end

   // Byte-lane writes into the backing memory
   // NOTE: the memory has no reset, so contents survive ARESET and it maps onto plain RAM.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int i = 0; i < NB; i++) begin
            if (lane_we[i]) begin
               mem[wr_idx][8*i +: 8] <= WDATA[8*i +: 8];
            end
         end
      end
   end

   assign dbg_rdata = mem[dbg_addr];
   assign AWREADY   = awready_q;
   assign WREADY    = wready_q;
   assign BVALID    = bvalid_q;
   assign BRESP     = bresp_q;

endmodule
